kamus_lsu: RTL and testbench

Load/store unit for the kamus RISC-V core, sitting directly downstream of the execute stage. It consumes one decoded memory operation at a time (address computed by EX, width from `mem_width_e`, signedness from the load flavour), drives a word-oriented request/grant/response data-memory port, and returns aligned, sign- or zero-extended load data to writeback as the `MEM_RESULT` source. Misaligned and illegal-width accesses are flagged without touching the bus.

---
 rtl/kamus_lsu.sv | 155 +++++++++++++++
 tb/tb_kamus_lsu.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/kamus_lsu.sv
// rtl/kamus_lsu.sv - load/store unit: one memory op at a time over a req/gnt/rvalid data port
module kamus_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [1:0]        lsu_width_i,
    input  logic              lsu_unsigned_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              lsu_busy_o,
    output logic              lsu_done_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_misaligned_o,
    output logic              lsu_err_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    input  logic              data_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic              accept;
    logic              bad_width;
    logic              bad_align;
    logic [3:0]        be_d;
    logic [DATA_W-1:0] wdata_d;
    logic [1:0]        width_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_ext;

    assign accept = (state_q == S_IDLE) && lsu_req_i;

    always_comb begin
        bad_width = (lsu_width_i == 2'b11);
        bad_align = ((lsu_width_i == 2'b01) && lsu_addr_i[0]) ||
                    ((lsu_width_i == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = lsu_wdata_i;
        case (lsu_width_i)
            2'b00: begin
                be_d    = 4'b0001 << lsu_addr_i[1:0];
                wdata_d = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << lsu_addr_i[1:0];
                wdata_d = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = lsu_wdata_i;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend to full width.
    always_comb begin
        shifted  = data_rdata_i >> {off_q, 3'b000};
        load_ext = shifted;
        case (width_q)
            2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_req_i) begin
                    state_d = (bad_width || bad_align) ? S_DONE : S_REQ;
                end
            end
            S_REQ:   if (data_gnt_i)    state_d = S_RESP;
            S_RESP:  if (data_rvalid_i) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lsu_done_o = (state_q == S_DONE);
        lsu_busy_o = (state_q != S_IDLE) || lsu_req_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_req_o       <= 1'b0;
            data_we_o        <= 1'b0;
            data_be_o        <= 4'b0000;
            data_addr_o      <= '0;
            data_wdata_o     <= '0;
            lsu_rdata_o      <= '0;
            lsu_misaligned_o <= 1'b0;
            lsu_err_o        <= 1'b0;
            width_q          <= 2'b00;
            uns_q            <= 1'b0;
            off_q            <= 2'b00;
        end else begin
            if (accept) begin
                width_q          <= lsu_width_i;
                uns_q            <= lsu_unsigned_i;
                off_q            <= lsu_addr_i[1:0];
                lsu_rdata_o      <= '0;
                lsu_misaligned_o <= bad_align && !bad_width;
                lsu_err_o        <= bad_width;
                // Rejected ops never touch the bus, so the port keeps its old values.
                if (!bad_width && !bad_align) begin
                    data_req_o   <= 1'b1;
                    data_we_o    <= lsu_we_i;
                    data_be_o    <= be_d;
                    data_addr_o  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
                    data_wdata_o <= wdata_d;
                end
            end
            if ((state_q == S_REQ) && data_gnt_i) begin
                data_req_o <= 1'b0;
            end
            if ((state_q == S_RESP) && data_rvalid_i) begin
                lsu_err_o   <= data_err_i;
                lsu_rdata_o <= (data_we_o || data_err_i) ? '0 : load_ext;
            end
        end
    end

endmodule

// File: tb/tb_kamus_lsu.sv
// tb/tb_kamus_lsu.sv - directed scoreboard bench for kamus_lsu
module tb_kamus_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [1:0]  lsu_width_i = 2'b00;
    logic        lsu_unsigned_i = 1'b0;
    logic [31:0] lsu_addr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        lsu_busy_o;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_misaligned_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic        data_err_i = 1'b0;

    kamus_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_width_i(lsu_width_i),
        .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_busy_o(lsu_busy_o), .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o),
        .lsu_misaligned_o(lsu_misaligned_o), .lsu_err_o(lsu_err_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic we, input logic [1:0] w, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input int gd, input int rd,
                          input logic [31:0] mem, input logic berr, input logic bus,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erdata,
                          input logic emis, input logic eerr);
        exp_t e;
        int   cyc;
        e.rdata = erdata;
        e.mis   = emis;
        e.err   = eerr;
        e.lat   = bus ? 3 + gd + rd : 1;
        @(negedge clk_i);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_width_i = w; lsu_unsigned_i = u;
        lsu_addr_i = a; lsu_wdata_i = wd;
        sb.push_back(e);
        #1 chk({tag, ".busy_accept"}, 32'(lsu_busy_o), 32'd1);
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        cyc = 1;
        if (bus) begin
            for (int n = 0; n <= gd; n++) begin
                chk({tag, ".req"}, 32'(data_req_o), 32'd1);
                chk({tag, ".addr"}, data_addr_o, {a[31:2], 2'b00});
                chk({tag, ".be_we"}, {27'd0, data_we_o, data_be_o}, {27'd0, we, ebe});
                chk({tag, ".wdata"}, data_wdata_o, ewd);
                if (n == gd) data_gnt_i = 1'b1;
                @(negedge clk_i);
                data_gnt_i = 1'b0;
                cyc++;
            end
            chk({tag, ".req_drop"}, 32'(data_req_o), 32'd0);
            for (int n = 0; n <= rd; n++) begin
                if (n == rd) begin
                    data_rvalid_i = 1'b1; data_rdata_i = mem; data_err_i = berr;
                end
                @(negedge clk_i);
                data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
                cyc++;
            end
        end else begin
            chk({tag, ".no_req"}, 32'(data_req_o), 32'd0);
        end
        for (int t = 0; t < 20 && !lsu_done_o; t++) begin
            @(negedge clk_i);
            cyc++;
        end
        chk({tag, ".done"}, 32'(lsu_done_o), 32'd1);
        e = sb.pop_front();
        chk({tag, ".latency"}, 32'(cyc), 32'(e.lat));
        chk({tag, ".rdata"}, lsu_rdata_o, e.rdata);
        chk({tag, ".flags"}, {30'd0, lsu_misaligned_o, lsu_err_o}, {30'd0, e.mis, e.err});
        @(negedge clk_i);
        chk({tag, ".done_pulse"}, {30'd0, lsu_done_o, lsu_busy_o}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        chk("reset.ctrl", {24'd0, data_req_o, data_we_o, data_be_o, lsu_done_o,
                           lsu_misaligned_o, lsu_err_o, lsu_busy_o}, 32'd0);
        chk("reset.addr", data_addr_o, 32'd0);
        chk("reset.wdata", data_wdata_o, 32'd0);
        chk("reset.rdata", lsu_rdata_o, 32'd0);

        // stray response while idle
        data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_5555;
        @(negedge clk_i);
        data_rvalid_i = 1'b0; data_rdata_i = '0;
        @(negedge clk_i);
        chk("stray.done", {30'd0, lsu_done_o, lsu_busy_o}, 32'd0);

        run_op("lb",  0, 2'b00, 0, 32'h1003, 32'h0, 0, 0, 32'h80FF_1234, 0, 1,
               4'b1000, 32'h0, 32'hFFFF_FF80, 0, 0);
        run_op("lbu", 0, 2'b00, 1, 32'h1003, 32'h0, 0, 0, 32'h80FF_1234, 0, 1,
               4'b1000, 32'h0, 32'h0000_0080, 0, 0);
        run_op("sh",  1, 2'b01, 0, 32'h2002, 32'hDEAD_BEEF, 3, 0, 32'hFFFF_FFFF, 0, 1,
               4'b1100, 32'hBEEF_BEEF, 32'h0, 0, 0);
        run_op("lw_mis", 0, 2'b10, 0, 32'h3001, 32'h0, 0, 0, 32'h0, 0, 0,
               4'b0000, 32'h0, 32'h0, 1, 0);
        run_op("w11", 0, 2'b11, 0, 32'h3000, 32'h0, 0, 0, 32'h0, 0, 0,
               4'b0000, 32'h0, 32'h0, 0, 1);
        run_op("lh_mis", 0, 2'b01, 0, 32'h3003, 32'h0, 0, 0, 32'h0, 0, 0,
               4'b0000, 32'h0, 32'h0, 1, 0);
        run_op("lw_err", 0, 2'b10, 0, 32'h4000, 32'h0, 0, 1, 32'h1234_5678, 1, 1,
               4'b1111, 32'h0, 32'h0, 0, 1);
        run_op("lh",  0, 2'b01, 0, 32'h5002, 32'h0, 1, 0, 32'h8001_7FFF, 0, 1,
               4'b1100, 32'h0, 32'hFFFF_8001, 0, 0);
        run_op("lhu", 0, 2'b01, 1, 32'h5000, 32'h0, 0, 0, 32'h8001_F00D, 0, 1,
               4'b0011, 32'h0, 32'h0000_F00D, 0, 0);
        run_op("sw",  1, 2'b10, 0, 32'h6000, 32'hCAFE_F00D, 0, 2, 32'h0, 0, 1,
               4'b1111, 32'hCAFE_F00D, 32'h0, 0, 0);
        run_op("sb",  1, 2'b00, 0, 32'h7001, 32'h1234_56A5, 1, 1, 32'h0, 0, 1,
               4'b0010, 32'hA5A5_A5A5, 32'h0, 0, 0);

        // reset while waiting for the response
        @(negedge clk_i);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_width_i = 2'b10; lsu_addr_i = 32'h4000;
        @(negedge clk_i);
        lsu_req_i = 1'b0; data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hAAAA_AAAA;
        chk("rst_mid.ctrl", {24'd0, data_req_o, data_we_o, data_be_o, lsu_done_o,
                             lsu_misaligned_o, lsu_err_o, lsu_busy_o}, 32'd0);
        chk("rst_mid.addr", data_addr_o, 32'd0);
        chk("rst_mid.rdata", lsu_rdata_o, 32'd0);
        @(negedge clk_i);
        data_rvalid_i = 1'b0; data_rdata_i = '0;
        chk("rst_mid.no_done", {30'd0, lsu_done_o, lsu_busy_o}, 32'd0);
        @(negedge clk_i);
        chk("rst_mid.no_done2", 32'(lsu_done_o), 32'd0);

        run_op("lw_after_rst", 0, 2'b10, 0, 32'h0000_0010, 32'h0, 0, 0, 32'h1122_3344, 0, 1,
               4'b1111, 32'h0, 32'h1122_3344, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
